// File: rtl/vga_pkg.sv
// Default 800x600@60 timing constants, derived totals and FSM state type for vga_timing_gen.
package vga_pkg;

   parameter int unsigned H_ACTIVE_DEF = 800;
   parameter int unsigned H_FP_DEF     = 40;
   parameter int unsigned H_SYNC_DEF   = 128;
   parameter int unsigned H_BP_DEF     = 88;
   parameter int unsigned V_ACTIVE_DEF = 600;
   parameter int unsigned V_FP_DEF     = 1;
   parameter int unsigned V_SYNC_DEF   = 4;
   parameter int unsigned V_BP_DEF     = 23;
   parameter int unsigned CNT_W_DEF    = 11;

   localparam int unsigned H_TOTAL_DEF      = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
   localparam int unsigned V_TOTAL_DEF      = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;
   localparam int unsigned H_SYNC_START_DEF = H_ACTIVE_DEF + H_FP_DEF;
   localparam int unsigned H_SYNC_END_DEF   = H_SYNC_START_DEF + H_SYNC_DEF - 1;
   localparam int unsigned V_SYNC_START_DEF = V_ACTIVE_DEF + V_FP_DEF;
   localparam int unsigned V_SYNC_END_DEF   = V_SYNC_START_DEF + V_SYNC_DEF - 1;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_e;

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping position counter with registered blank/sync decoded from the
// next-state count. clear forces the idle values (count 0, blanked, sync inactive).
module vga_axis_counter
   import vga_pkg::*;
#(
   parameter int unsigned ACTIVE = H_ACTIVE_DEF,
   parameter int unsigned FP     = H_FP_DEF,
   parameter int unsigned SYNC   = H_SYNC_DEF,
   parameter int unsigned BP     = H_BP_DEF,
   parameter bit          POL    = 1'b1,
   parameter int unsigned CNT_W  = CNT_W_DEF
) (
   input  logic             pclk,
   input  logic             rst_n,
   input  logic             step,
   input  logic             clear,
   output logic [CNT_W-1:0] count,
   output logic [CNT_W-1:0] count_nxt,
   output logic             blank,
   output logic             sync,
   output logic             last
);

   localparam logic [CNT_W-1:0] ACTIVE_C   = CNT_W'(ACTIVE);
   localparam logic [CNT_W-1:0] SYNC_S_C   = CNT_W'(ACTIVE + FP);
   localparam logic [CNT_W-1:0] SYNC_E_C   = CNT_W'(ACTIVE + FP + SYNC - 1);
   localparam logic [CNT_W-1:0] TOTAL_M1_C = CNT_W'(ACTIVE + FP + SYNC + BP - 1);

   logic in_sync;

   assign last = (count == TOTAL_M1_C);

   always_comb begin
      count_nxt = count;
      if (clear) begin
         count_nxt = '0;
      end else if (step) begin
         count_nxt = last ? '0 : count + 1'b1;
      end
   end

   assign in_sync = !clear && (count_nxt >= SYNC_S_C) && (count_nxt <= SYNC_E_C);

   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
         blank <= 1'b1;
         sync  <= !POL;
      end else begin
         count <= count_nxt;
         blank <= clear || (count_nxt >= ACTIVE_C);
         sync  <= in_sync ? POL : !POL;
      end
   end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator with frame-aligned start/stop FSM.
// Optional VGA_TIMING_GEN_FRAME_CNT_EN adds a 16-bit frame counter output.
module vga_timing_gen
   import vga_pkg::*;
#(
   parameter int unsigned H_ACTIVE   = H_ACTIVE_DEF,
   parameter int unsigned H_FP       = H_FP_DEF,
   parameter int unsigned H_SYNC     = H_SYNC_DEF,
   parameter int unsigned H_BP       = H_BP_DEF,
   parameter int unsigned V_ACTIVE   = V_ACTIVE_DEF,
   parameter int unsigned V_FP       = V_FP_DEF,
   parameter int unsigned V_SYNC     = V_SYNC_DEF,
   parameter int unsigned V_BP       = V_BP_DEF,
   parameter bit          H_SYNC_POL = 1'b1,
   parameter bit          V_SYNC_POL = 1'b1,
   parameter int unsigned CNT_W      = CNT_W_DEF
) (
   input  logic             pclk,
   input  logic             rst_n,
   input  logic             en,
   output logic [CNT_W-1:0] hcount,
   output logic [CNT_W-1:0] vcount,
   output logic             hblnk,
   output logic             vblnk,
   output logic             hsync,
   output logic             vsync,
   output logic             de,
   output logic             line_start,
   output logic             frame_start
`ifdef VGA_TIMING_GEN_FRAME_CNT_EN
   ,
   output logic [15:0]      frame_cnt
`endif
);

   localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam logic [CNT_W-1:0] H_ACT_C = CNT_W'(H_ACTIVE);
   localparam logic [CNT_W-1:0] V_ACT_C = CNT_W'(V_ACTIVE);

   if ((2 ** CNT_W) < H_TOTAL || (2 ** CNT_W) < V_TOTAL) begin : g_cnt_w_check
      $error("vga_timing_gen: CNT_W too small for H_TOTAL/V_TOTAL");
   end

   state_e           state_q, state_d;
   logic             run_d, h_step, v_step, h_last, v_last;
   logic [CNT_W-1:0] h_nxt, v_nxt;

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: if (en) state_d = RUN;
         RUN:  if (h_last && v_last && !en) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign run_d = (state_d == RUN);
   // Counters hold at 0 on the IDLE->RUN edge so the first running cycle is (0,0).
   assign h_step = (state_q == RUN) && run_d;
   assign v_step = h_step && h_last;

   vga_axis_counter #(
      .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .POL(H_SYNC_POL), .CNT_W(CNT_W)
   ) u_h (
      .pclk(pclk), .rst_n(rst_n), .step(h_step), .clear(!run_d),
      .count(hcount), .count_nxt(h_nxt), .blank(hblnk), .sync(hsync), .last(h_last)
   );

   vga_axis_counter #(
      .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .POL(V_SYNC_POL), .CNT_W(CNT_W)
   ) u_v (
      .pclk(pclk), .rst_n(rst_n), .step(v_step), .clear(!run_d),
      .count(vcount), .count_nxt(v_nxt), .blank(vblnk), .sync(vsync), .last(v_last)
   );

   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         de          <= 1'b0;
         line_start  <= 1'b0;
         frame_start <= 1'b0;
`ifdef VGA_TIMING_GEN_FRAME_CNT_EN
         frame_cnt   <= '0;
`endif
      end else begin
         state_q     <= state_d;
         de          <= run_d && (h_nxt < H_ACT_C) && (v_nxt < V_ACT_C);
         line_start  <= run_d && (h_nxt == '0);
         frame_start <= run_d && (h_nxt == '0) && (v_nxt == '0);
`ifdef VGA_TIMING_GEN_FRAME_CNT_EN
         if (run_d && (h_nxt == '0) && (v_nxt == '0)) frame_cnt <= frame_cnt + 16'd1;
`endif
      end
   end

endmodule
